// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the dual-bank register file: arbitrates ports A/B into a FIFO,
// drains one entry per cycle and flags read-after-write hazards. Optional macro: WB_BYPASS_EN.
module regfile_wb_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [1:0]    a_fpoint,
   input  logic [4:0]    a_rd,
   input  logic [31:0]   a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [1:0]    b_fpoint,
   input  logic [4:0]    b_rd,
   input  logic [31:0]   b_data,
   input  logic          hold,
   input  logic [4:0]    q_rs,
   input  logic [4:0]    q_rt,
   input  logic          q_fp,
   output logic          hazard,
   output logic          wb_write,
   output logic [1:0]    wb_fpoint,
   output logic [4:0]    wb_rd,
   output logic [31:0]   wb_busW,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RD_W   = 5;
   localparam int unsigned FP_W   = 2;
   localparam int unsigned EW     = FP_W + RD_W + DATA_W;
   localparam int unsigned RD_LSB = DATA_W;
   localparam int unsigned FP_LSB = DATA_W + RD_W;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic          pop;
   logic          bypass;
   logic          push_a;
   logic          push_b;
   logic [AW+1:0] free;
   logic [EW-1:0] head;
   logic [AW-1:0] hz_off;

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // Arbitration: a same-cycle pop frees a slot; port A has fixed priority
   always_comb begin : arbitrate
      bypass = 1'b0;
      pop    = !empty && !hold;
`ifdef WB_BYPASS_EN
      bypass = empty && !hold && a_valid && !reset;
`endif
      free    = (AW+2)'(DEPTH) - (AW+2)'(count_q) + (AW+2)'(pop);
      a_ready = !reset && (free >= (AW+2)'(1));
      b_ready = !reset && ((free >= (AW+2)'(2)) ||
                           ((free >= (AW+2)'(1)) && !a_valid));
      push_a  = a_valid && a_ready && !bypass;
      push_b  = b_valid && b_ready;
   end

   // Next-state for storage and pointers; A lands before B when both push
   always_comb begin : next_state
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_a) begin
         mem_d[wr_ptr_q] = {a_fpoint, a_rd, a_data};
      end
      if (push_b) begin
         mem_d[wr_ptr_q + AW'(push_a)] = {b_fpoint, b_rd, b_data};
      end
      wr_ptr_d = wr_ptr_q + AW'(push_a) + AW'(push_b);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
   end

   // Register-file write port, zeroed when idle
   always_comb begin : wb_drive
      wb_write  = 1'b0;
      wb_fpoint = '0;
      wb_rd     = '0;
      wb_busW   = '0;
      if (bypass) begin
         wb_write  = 1'b1;
         wb_fpoint = a_fpoint;
         wb_rd     = a_rd;
         wb_busW   = a_data;
      end else if (pop) begin
         wb_write  = 1'b1;
         wb_fpoint = head[FP_LSB +: FP_W];
         wb_rd     = head[RD_LSB +: RD_W];
         wb_busW   = head[DATA_W-1:0];
      end
   end

   // Slot i is occupied when its distance from the head is below count; fpoint[0] selects the bank
   always_comb begin : hazard_detect
      hazard = 1'b0;
      hz_off = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         hz_off = AW'(i) - rd_ptr_q;
         if (((AW+1)'(hz_off) < count_q) && (mem_q[i][FP_LSB] == q_fp) &&
             ((mem_q[i][RD_LSB +: RD_W] == q_rs) || (mem_q[i][RD_LSB +: RD_W] == q_rt))) begin
            hazard = 1'b1;
         end
      end
      if (bypass && (a_fpoint[0] == q_fp) && ((a_rd == q_rs) || (a_rd == q_rt))) begin
         hazard = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin : state_reg
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule
